multiword_sub_ctrl: RTL
=======================

// Module: multiword_sub_ctrl
// PURPOSE
//  Sequences one W-bit ripple-borrow subtractor slice over WORDS cycles to subtract
//  two W*WORDS-bit operands, least-significant slice first, carrying the borrow
//  between cycles in a register. Sits between an operand producer and a result
//  consumer, with valid/ready handshakes on both sides. Trades latency for area
//  compared with a full-width ripple chain.
// PARAMETERS
//  W      4  bit width of the subtractor slice used each cycle
//  WORDS  8  slices per operation; total operand width TW = W*WORDS
// PORTS
//  clk          in   1   single clock; all logic on the rising edge
//  rst          in   1   synchronous reset, active-high
//  in_valid     in   1   operands A, B and Bin are valid
//  in_ready     out  1   block can accept operands (high only in IDLE)
//  A            in   TW  minuend
//  B            in   TW  subtrahend
//  Bin          in   1   borrow-in to slice 0
//  out_valid    out  1   Diff and Bout are valid
//  out_ready    in   1   consumer accepts the result
//  Diff         out  TW  A - B - Bin, modulo 2^TW
//  Bout         out  1   final borrow: 1 iff A < B + Bin (unsigned)
//  busy         out  1   high in RUN or DONE
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; Diff=0; Bout=0; slice
//    counter=0; borrow register=0. rst has priority over every other event.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: if in_valid && in_ready, latch A, B and Bin; clear Diff and the counter;
//      move to RUN.
//    RUN: each cycle, slice k = A[k*W+:W] - B[k*W+:W] - borrow. Write the result to
//      Diff[k*W+:W], load the slice borrow-out into the borrow register, then k++.
//      When k == WORDS-1, set Bout to the slice borrow-out and move to DONE.
//    DONE: out_valid=1. Diff and Bout stay stable until out_ready. On
//      out_valid && out_ready, go to IDLE.
//  - Latency: accept at edge t gives out_valid high after edge t+WORDS. Throughput
//    is one operation per WORDS+2 cycles when out_ready is held high.
//  - Operands are captured at accept time. Input changes during RUN/DONE are ignored.
//  - in_valid during RUN/DONE is not consumed. in_ready stays low in those states.
//  - Counter width is clog2(WORDS), minimum 1. WORDS=1 is legal (one RUN cycle).
//  - Reset mid-RUN or mid-DONE: the operation is discarded and no out_valid pulse
//    occurs.
// CONFIGURATION
//  SUB_FLAGS_EN defined: adds outputs zero (1 iff Diff==0) and ovf (two's-complement
//    overflow = (A[TW-1]!=B[TW-1]) && (Diff[TW-1]!=A[TW-1])). Both are registered
//    on entry to DONE, valid with out_valid, and reset to 0.
//  SUB_FLAGS_EN undefined: neither port nor its logic exists. All other behaviour
//    is identical.
// STRUCTURE
//  - Shared package sub_ctrl_pkg: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2,
//    and a clog2 helper function.
//  - One sub-module: the existing ripple_borrow_sub #(.N(W)), instantiated once as
//    the per-cycle slice datapath. Its Bin is driven by the borrow register.
//  - Operand and Diff registers are indexed by the slice counter; no shifting.
// TESTING  (W=4, WORDS=8)
//  1 A=0x00000010, B=0x00000001, Bin=0 -> Diff=0x0000000F, Bout=0; out_valid
//    exactly 8 cycles after accept.
//  2 A=0, B=0, Bin=1 -> Diff=0xFFFFFFFF, Bout=1. Checks the borrow ripples
//    across all 8 cycle boundaries.
//  3 Backpressure: hold out_ready=0 for 5 cycles in DONE -> Diff, Bout and
//    out_valid are stable. in_ready=0 throughout. Accept on the 6th cycle.
//  4 Assert rst on RUN cycle 3 -> next cycle IDLE, in_ready=1, out_valid=0,
//    Diff=0. A new operation then completes correctly.
//  5 SUB_FLAGS_EN: A=0x80000000, B=1 -> ovf=1, zero=0. A=B=0x12345678 ->
//    zero=1, ovf=0, Bout=0.
//  6 1000 random back-to-back operations with random out_ready stalls ->
//    every result matches {Bout,Diff} = {1'b0,A} - B - Bin.

Source files
------------

// File: rtl/sub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_ctrl_pkg
// Description : Shared state encodings and sizing helper for the multi-word
//               subtract sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to index n items, never less than one so WORDS=1 still
   // yields a usable counter.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage : sub_ctrl_pkg
`default_nettype wire

// File: rtl/ripple_borrow_sub.sv
`default_nettype none
// ============================================================================
// Module      : ripple_borrow_sub
// Description : N-bit combinational ripple-borrow subtractor, a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_borrow_sub #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic [N-1:0] diff,
   output logic         bout
);

   logic [N:0] w_borrow;

   assign w_borrow[0] = bin;

   for (genvar g = 0; g < N; g++) begin : g_bit
      assign diff[g]       = a[g] ^ b[g] ^ w_borrow[g];
      // Borrow out when the minuend bit cannot cover subtrahend plus borrow.
      assign w_borrow[g+1] = (~a[g] & b[g]) | (~(a[g] ^ b[g]) & w_borrow[g]);
   end

   assign bout = w_borrow[N];

endmodule : ripple_borrow_sub
`default_nettype wire

// File: rtl/multiword_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multiword_sub_ctrl
// Description : Subtracts two W*WORDS-bit operands one W-bit slice per cycle,
//               LSB slice first, with valid/ready on both sides.
//               Optional macro SUB_FLAGS_EN adds zero/ovf result flags.
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_sub_ctrl
   import sub_ctrl_pkg::*;
#(
   parameter int W     = 4,
   parameter int WORDS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W*WORDS-1:0]   A,
   input  logic [W*WORDS-1:0]   B,
   input  logic                 Bin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W*WORDS-1:0]   Diff,
   output logic                 Bout,
   output logic                 busy
`ifdef SUB_FLAGS_EN
  ,output logic                 zero,
   output logic                 ovf
`endif
);

   localparam int             c_tw   = W * WORDS;
   localparam int             c_cw   = clog2_min1(WORDS);
   localparam logic [c_cw-1:0] c_last = c_cw'(WORDS - 1);

   state_t          r_state;
   state_t          w_state_next;

   logic [c_tw-1:0] r_a;
   logic [c_tw-1:0] r_b;
   logic [c_tw-1:0] r_diff;
   logic [c_tw-1:0] w_diff_next;
   logic [c_cw-1:0] r_cnt;
   logic            r_borrow;
   logic            r_bout;

   logic [W-1:0]    w_a_words [WORDS];
   logic [W-1:0]    w_b_words [WORDS];
   logic [W-1:0]    w_slice_diff;
   logic            w_slice_bout;
   logic            w_accept;
   logic            w_last;

   // Slice views of the held operands and the Diff image after this cycle's
   // write; the counter selects the slice, nothing is ever shifted.
   for (genvar g = 0; g < WORDS; g++) begin : g_word
      assign w_a_words[g] = r_a[g*W +: W];
      assign w_b_words[g] = r_b[g*W +: W];
      assign w_diff_next[g*W +: W] = (r_cnt == c_cw'(g)) ? w_slice_diff
                                                          : r_diff[g*W +: W];
   end

   ripple_borrow_sub #(
      .N    (W)
   ) u_slice (
      .a    (w_a_words[r_cnt]),
      .b    (w_b_words[r_cnt]),
      .bin  (r_borrow),
      .diff (w_slice_diff),
      .bout (w_slice_bout)
   );

   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_last    = (r_cnt == c_last);

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign Diff      = r_diff;
   assign Bout      = r_bout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_next = RUN;
         RUN:     if (w_last)    w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default:                w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
      end else if (w_accept) begin
         r_a      <= A;
         r_b      <= B;
         r_borrow <= Bin;
         r_diff   <= '0;
         r_cnt    <= '0;
      end else if (r_state == RUN) begin
         r_diff   <= w_diff_next;
         r_borrow <= w_slice_bout;
         if (w_last) begin
            r_bout <= w_slice_bout;
         end else begin
            r_cnt  <= r_cnt + 1'b1;
         end
      end
   end

`ifdef SUB_FLAGS_EN
   logic r_zero;
   logic r_ovf;

   // Flags are taken from the completed Diff image as DONE is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if ((r_state == RUN) && w_last) begin
         r_zero <= (w_diff_next == '0);
         r_ovf  <= (r_a[c_tw-1] != r_b[c_tw-1]) &&
                   (w_diff_next[c_tw-1] != r_a[c_tw-1]);
      end
   end

   assign zero = r_zero;
   assign ovf  = r_ovf;
`endif

endmodule : multiword_sub_ctrl
`default_nettype wire
